// File: rtl/decode_low_scan_if.sv
// ---------------------------------------------------------------------------
// decode_low_scan_if
//
// Purpose:
//    Bundles the control inputs and decoded outputs of decode_low_scan so
//    that the decoder and its user connect through one port.
//
// Signals (N = 2**SEL_W):
//    en       decoder enable; low forces every output inactive (high)
//    mode     0 = manual decode of sel, 1 = auto-scan
//    sel      manual select index (SEL_W bits)
//    d_n      active-low decoded outputs (N bits), at most one bit low
//    cur_sel  index currently driven low (SEL_W bits)
//    wrap     one-cycle pulse when the scan index wraps from N-1 to 0
//
// Modports:
//    master   the block that drives en/mode/sel and consumes the outputs
//    slave    the decoder itself
//
// SEL_W here must match the SEL_W of the decoder it is connected to.
// ---------------------------------------------------------------------------
interface decode_low_scan_if #(
    parameter int SEL_W = 2
);
    localparam int N = 2 ** SEL_W;

    logic             en;
    logic             mode;
    logic [SEL_W-1:0] sel;
    logic [N-1:0]     d_n;
    logic [SEL_W-1:0] cur_sel;
    logic             wrap;

    modport master (
        output en,
        output mode,
        output sel,
        input  d_n,
        input  cur_sel,
        input  wrap
    );

    modport slave (
        input  en,
        input  mode,
        input  sel,
        output d_n,
        output cur_sel,
        output wrap
    );
endinterface

// File: rtl/decode_low_scan.sv
// ---------------------------------------------------------------------------
// decode_low_scan
//
// Purpose:
//    Registered, active-low 1-of-N decoder (N = 2**SEL_W) for row/digit
//    strobes and chip selects. In manual mode it decodes an external select;
//    in scan mode it walks through every output on its own, holding each one
//    low for DWELL cycles and pulsing wrap when it returns to index 0.
//
// Parameters:
//    SEL_W    select width, N = 2**SEL_W outputs (SEL_W >= 1)
//    DWELL    cycles each output stays low while scanning (DWELL >= 1)
//
// Ports:
//    clk      rising-edge clock
//    rst      synchronous, active-high reset (highest priority)
//    bus      decode_low_scan_if.slave: en, mode, sel in; d_n, cur_sel,
//             wrap out. Every output comes straight from a register.
// ---------------------------------------------------------------------------
module decode_low_scan #(
    parameter int SEL_W = 2,
    parameter int DWELL = 4
) (
    input logic           clk,
    input logic           rst,
    decode_low_scan_if.slave bus
);
    localparam int N     = 2 ** SEL_W;
    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL - 1);
    localparam logic [SEL_W-1:0] TOP_SEL  = SEL_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        MANUAL,
        SCAN
    } state_t;

    state_t           r_state;
    state_t           w_nextState;
    logic [N-1:0]     r_dN;
    logic [N-1:0]     w_dN;
    logic [SEL_W-1:0] r_curSel;
    logic [SEL_W-1:0] w_curSel;
    logic [SEL_W-1:0] w_stepSel;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt;
    logic             r_wrap;
    logic             w_wrap;
    logic             r_scanActive;
    logic             w_scanActive;

    // Single-bit-low pattern for an index; only one bit can ever be low.
    function automatic logic [N-1:0] lowHot(input logic [SEL_W-1:0] idx);
        logic [N-1:0] one;
        one = {{(N-1){1'b0}}, 1'b1};
        return ~(one << idx);
    endfunction

    // Next scan index; the SEL_W-bit add wraps N-1 back to 0 by itself.
    assign w_stepSel = r_curSel + 1'b1;

    // Next-state and next-output logic. The target state is chosen from the
    // en/mode sampled this cycle, and the register updates for that target
    // are produced in the same pass so outputs appear one cycle after the
    // inputs. Scan progress (index, dwell count, scan_active) is kept across
    // IDLE so a paused scan resumes where it stopped; only MANUAL or reset
    // throw it away. On resume the first cycle already counts as a dwell
    // step, so the interrupted index finishes exactly its remaining cycles.
    always_comb begin
        w_nextState  = IDLE;
        w_dN         = r_dN;
        w_curSel     = r_curSel;
        w_cnt        = r_cnt;
        w_wrap       = 1'b0;
        w_scanActive = r_scanActive;

        if (bus.en) begin
            w_nextState = bus.mode ? SCAN : MANUAL;
        end

        case (w_nextState)
            IDLE: begin
                w_dN = '1;
            end
            MANUAL: begin
                w_dN         = lowHot(bus.sel);
                w_curSel     = bus.sel;
                w_cnt        = '0;
                w_scanActive = 1'b0;
            end
            SCAN: begin
                if (r_state == SCAN || r_scanActive) begin
                    if (r_cnt == LAST_CNT) begin
                        w_cnt    = '0;
                        w_curSel = w_stepSel;
                        w_dN     = lowHot(w_stepSel);
                        w_wrap   = (r_curSel == TOP_SEL);
                    end else begin
                        w_cnt = r_cnt + 1'b1;
                        w_dN  = lowHot(r_curSel);
                    end
                end else begin
                    w_cnt        = '0;
                    w_curSel     = '0;
                    w_dN         = lowHot('0);
                    w_scanActive = 1'b1;
                end
            end
            default: begin
                w_dN = '1;
            end
        endcase
    end

    // State and output registers. Reset parks everything inactive and
    // clears scan progress so the next scan starts at index 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_dN         <= '1;
            r_curSel     <= '0;
            r_cnt        <= '0;
            r_wrap       <= 1'b0;
            r_scanActive <= 1'b0;
        end else begin
            r_state      <= w_nextState;
            r_dN         <= w_dN;
            r_curSel     <= w_curSel;
            r_cnt        <= w_cnt;
            r_wrap       <= w_wrap;
            r_scanActive <= w_scanActive;
        end
    end

    assign bus.d_n     = r_dN;
    assign bus.cur_sel = r_curSel;
    assign bus.wrap    = r_wrap;
endmodule

// File: tb/tb_decode_low_scan.sv
// ---------------------------------------------------------------------------
// tb_decode_low_scan
//
// Purpose:
//    Self-checking bench for decode_low_scan. Two instances are exercised:
//    unit A (SEL_W=2, DWELL=4) and unit B (SEL_W=3, DWELL=1). A table of
//    {inputs, expected outputs} records is applied one per clock; each
//    record's expectation is queued when it is driven and popped once the
//    decoder has registered it.
// ---------------------------------------------------------------------------
module tb_decode_low_scan;
    typedef struct {
        bit         unitB;
        bit         rst;
        bit         en;
        bit         mode;
        logic [2:0] sel;
        logic [7:0] expD;
        logic [2:0] expSel;
        bit         expWrap;
        string      name;
    } vec_t;

    logic clk;
    logic rstA;
    logic rstB;

    int errors;
    int checks;

    vec_t vecs[$];
    vec_t pending[$];

    decode_low_scan_if #(.SEL_W(2)) ifA ();
    decode_low_scan_if #(.SEL_W(3)) ifB ();

    decode_low_scan #(.SEL_W(2), .DWELL(4)) dutA (
        .clk (clk),
        .rst (rstA),
        .bus (ifA.slave)
    );

    decode_low_scan #(.SEL_W(3), .DWELL(1)) dutB (
        .clk (clk),
        .rst (rstB),
        .bus (ifB.slave)
    );

    // 10 ns clock; inputs change and outputs are sampled on the falling edge.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the stimulus loop ever stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Expected active-low pattern for a 4-output and an 8-output decoder.
    function automatic logic [7:0] expA(input int idx);
        logic [3:0] v;
        v = 4'b0001 << idx;
        return {4'h0, ~v};
    endfunction

    function automatic logic [7:0] expB(input int idx);
        logic [7:0] v;
        v = 8'h01 << idx;
        return ~v;
    endfunction

    function automatic void addVec(input bit unitB, input bit rst, input bit en,
                                   input bit mode, input int sel,
                                   input logic [7:0] expD, input int expSel,
                                   input bit expWrap, input string name);
        vec_t v;
        v.unitB   = unitB;
        v.rst     = rst;
        v.en      = en;
        v.mode    = mode;
        v.sel     = 3'(sel);
        v.expD    = expD;
        v.expSel  = 3'(expSel);
        v.expWrap = expWrap;
        v.name    = name;
        vecs.push_back(v);
    endfunction

    // Drive one record onto its unit; the other unit is held in reset.
    task automatic applyStimulus(input vec_t v);
        if (!v.unitB) begin
            rstA     = v.rst;
            ifA.en   = v.en;
            ifA.mode = v.mode;
            ifA.sel  = v.sel[1:0];
            rstB     = 1'b1;
            ifB.en   = 1'b0;
            ifB.mode = 1'b0;
            ifB.sel  = '0;
        end else begin
            rstB     = v.rst;
            ifB.en   = v.en;
            ifB.mode = v.mode;
            ifB.sel  = v.sel;
            rstA     = 1'b1;
            ifA.en   = 1'b0;
            ifA.mode = 1'b0;
            ifA.sel  = '0;
        end
    endtask

    // Compare the registered outputs against one popped expectation.
    task automatic checkOutput(input vec_t v);
        logic [7:0] actD;
        logic [2:0] actSel;
        logic       actWrap;
        int         lowCount;
        if (!v.unitB) begin
            actD     = {4'h0, ifA.d_n};
            actSel   = {1'b0, ifA.cur_sel};
            actWrap  = ifA.wrap;
            lowCount = $countones(~ifA.d_n);
        end else begin
            actD     = ifB.d_n;
            actSel   = ifB.cur_sel;
            actWrap  = ifB.wrap;
            lowCount = $countones(~ifB.d_n);
        end

        checks++;
        if (actD !== v.expD) begin
            errors++;
            $display("[TB] FAIL %s d_n: actual=%h required=%h", v.name, actD, v.expD);
        end
        checks++;
        if (actSel !== v.expSel) begin
            errors++;
            $display("[TB] FAIL %s cur_sel: actual=%0d required=%0d", v.name, actSel, v.expSel);
        end
        checks++;
        if (actWrap !== v.expWrap) begin
            errors++;
            $display("[TB] FAIL %s wrap: actual=%b required=%b", v.name, actWrap, v.expWrap);
        end
        checks++;
        if (lowCount > 1) begin
            errors++;
            $display("[TB] FAIL %s onehot: actual=%0d low bits required<=1", v.name, lowCount);
        end
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        rstA     = 1'b1;
        rstB     = 1'b1;
        ifA.en   = 1'b0;
        ifA.mode = 1'b0;
        ifA.sel  = '0;
        ifB.en   = 1'b0;
        ifB.mode = 1'b0;
        ifB.sel  = '0;

        // Unit A: reset, manual decode, sweep, disable, reset priority.
        addVec(0, 1, 0, 0, 0, 8'h0F, 0, 0, "rstA");
        addVec(0, 1, 0, 0, 0, 8'h0F, 0, 0, "rstA");
        addVec(0, 0, 1, 0, 2, 8'h0B, 2, 0, "man2");
        for (int s = 0; s < 4; s++) addVec(0, 0, 1, 0, s, expA(s), s, 0, "sweep");
        addVec(0, 0, 0, 0, 3, 8'h0F, 3, 0, "disable");
        addVec(0, 1, 1, 0, 2, 8'h0F, 0, 0, "rstPri");

        // Unit A: full scan period of 16 cycles plus the wrap cycle.
        for (int v = 0; v < 18; v++)
            addVec(0, 0, 1, 1, 0, expA((v / 4) % 4), (v / 4) % 4, (v == 16), "scan");

        // Unit A: pause at index 2 after one dwell cycle, then resume.
        addVec(0, 1, 0, 0, 0, 8'h0F, 0, 0, "rstA");
        for (int v = 0; v < 9; v++)
            addVec(0, 0, 1, 1, 0, expA(v / 4), v / 4, 0, "scanPre");
        for (int v = 0; v < 5; v++) addVec(0, 0, 0, 1, 0, 8'h0F, 2, 0, "pause");
        for (int v = 0; v < 3; v++) addVec(0, 0, 1, 1, 0, expA(2), 2, 0, "resume");
        for (int v = 0; v < 2; v++) addVec(0, 0, 1, 1, 0, expA(3), 3, 0, "idx3");

        // Unit A: manual interrupt then scan restarts at 0 with no wrap.
        addVec(0, 0, 1, 0, 1, expA(1), 1, 0, "toMan");
        for (int v = 0; v < 5; v++)
            addVec(0, 0, 1, 1, 0, expA(v / 4), v / 4, 0, "rescan");

        // Unit B: DWELL=1 rotation over 8 outputs, reset mid-scan, restart.
        addVec(1, 1, 0, 0, 0, 8'hFF, 0, 0, "rstB");
        for (int v = 0; v < 20; v++)
            addVec(1, 0, 1, 1, 0, expB(v % 8), v % 8, (v % 8 == 0) && (v > 0), "rot");
        addVec(1, 1, 1, 1, 0, 8'hFF, 0, 0, "rstMid");
        addVec(1, 0, 1, 1, 0, expB(0), 0, 0, "restart0");
        addVec(1, 0, 1, 1, 0, expB(1), 1, 0, "restart1");

        foreach (vecs[i]) begin
            @(negedge clk);
            if (pending.size() > 0) checkOutput(pending.pop_front());
            applyStimulus(vecs[i]);
            pending.push_back(vecs[i]);
        end
        @(negedge clk);
        while (pending.size() > 0) checkOutput(pending.pop_front());

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
